// File: rtl/dac_controller.sv
// Paced DAC sample controller: small sample FIFO, sample-period tick, load/busy handshake FSM.
// Optional busy-handshake timeout is enabled by defining DAC_BUSY_TIMEOUT_EN.
module dac_controller #(
   parameter int DW = 10,
   parameter int AW = 2,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          sreset_n,
   input  logic          dac_en,
   input  logic [PW-1:0] dac_period,
   input  logic [DW-1:0] smp_data,
   input  logic          smp_valid,
   output logic          smp_ready,
   input  logic          dac_busy,
   output logic [DW-1:0] dac_data_out,
   output logic          dac_load,
   output logic          dac_underrun,
   output logic          dac_err,
   output logic [AW:0]   fifo_level
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_TICK, LOAD, WAIT_HI, WAIT_LO} state_t;

   state_t        r_state;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [PW-1:0] r_tick_cnt;
   logic          r_busy_meta;
   logic          r_busy_s;
   logic [DW-1:0] r_data_out;
   logic          r_load;
   logic          r_underrun;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_tick;

   assign w_full    = (r_level == FULL_LEVEL);
   assign w_empty   = (r_level == '0);
   assign w_push    = smp_valid && !w_full;
   assign w_tick    = (r_state == WAIT_TICK) && (r_tick_cnt == dac_period);
   // Disabling wins over a coincident tick, so nothing is popped on the way to IDLE.
   assign w_pop     = w_tick && dac_en && !w_empty;

   assign smp_ready    = !w_full;
   assign fifo_level   = r_level;
   assign dac_data_out = r_data_out;
   assign dac_load     = r_load;
   assign dac_underrun = r_underrun;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= smp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         r_busy_meta <= 1'b0;
         r_busy_s    <= 1'b0;
      end else begin
         r_busy_meta <= dac_busy;
         r_busy_s    <= r_busy_meta;
      end
   end

   // Held at zero outside WAIT_TICK, so every entry starts a fresh period.
   always_ff @(posedge clk) begin
      if (!sreset_n || r_state != WAIT_TICK || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

`ifdef DAC_BUSY_TIMEOUT_EN
   logic [3:0] r_to_cnt;
   logic       r_err;

   assign dac_err = r_err;

   always_ff @(posedge clk) begin
      if (!sreset_n || r_state != WAIT_HI) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign dac_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         r_state    <= IDLE;
         r_data_out <= '0;
         r_load     <= 1'b0;
         r_underrun <= 1'b0;
`ifdef DAC_BUSY_TIMEOUT_EN
         r_err      <= 1'b0;
`endif
      end else begin
         r_load     <= 1'b0;
         r_underrun <= 1'b0;
`ifdef DAC_BUSY_TIMEOUT_EN
         r_err      <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (dac_en) r_state <= WAIT_TICK;
            end
            WAIT_TICK: begin
               if (!dac_en) begin
                  r_state <= IDLE;
               end else if (w_tick) begin
                  if (!w_empty) begin
                     r_data_out <= r_mem[r_rd_ptr];
                     r_state    <= LOAD;
                  end else begin
                     r_underrun <= 1'b1;
                  end
               end
            end
            LOAD: begin
               r_load  <= 1'b1;
               r_state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (r_busy_s) begin
                  r_state <= WAIT_LO;
`ifdef DAC_BUSY_TIMEOUT_EN
               end else if (r_to_cnt == 4'd15) begin
                  r_err   <= 1'b1;
                  r_state <= dac_en ? WAIT_TICK : IDLE;
`endif
               end
            end
            WAIT_LO: begin
               if (!r_busy_s) r_state <= dac_en ? WAIT_TICK : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_controller.sv
// Self-checking bench for dac_controller: FIFO scoreboard for loaded samples plus directed
// scenarios for fill, underrun, disable mid-transfer, busy timeout and reset mid-transfer.
module tb_dac_controller;

   localparam int DW = 10;
   localparam int AW = 2;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          sreset_n;
   logic          dac_en;
   logic [PW-1:0] dac_period;
   logic [DW-1:0] smp_data;
   logic          smp_valid;
   logic          smp_ready;
   logic          dac_busy = 1'b0;
   logic [DW-1:0] dac_data_out;
   logic          dac_load;
   logic          dac_underrun;
   logic          dac_err;
   logic [AW:0]   fifo_level;

   int compared = 0;
   int mismatched = 0;
   int cycleNum = 0;
   int loads = 0;
   int underruns = 0;
   int errs = 0;
   int lastLoadCycle = 0;
   int prevLoadCycle = 0;
   int errCycle = 0;
   logic [DW-1:0] lastExpData = '0;
   logic [DW-1:0] expQ[$];

   logic       busyModelOn = 1'b0;
   logic [5:0] loadHist = '0;

   dac_controller #(.DW(DW), .AW(AW), .PW(PW)) dut (
      .clk          (clk),
      .sreset_n     (sreset_n),
      .dac_en       (dac_en),
      .dac_period   (dac_period),
      .smp_data     (smp_data),
      .smp_valid    (smp_valid),
      .smp_ready    (smp_ready),
      .dac_busy     (dac_busy),
      .dac_data_out (dac_data_out),
      .dac_load     (dac_load),
      .dac_underrun (dac_underrun),
      .dac_err      (dac_err),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   // DAC model: busy rises one cycle after a load and stays high for five cycles.
   always @(negedge clk) begin
      loadHist = {loadHist[4:0], dac_load};
      dac_busy = busyModelOn && (|loadHist[5:1]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: account for an accepted push, then sample outputs at the falling edge.
   task automatic stepCycle();
      logic [DW-1:0] front;
      if (smp_valid === 1'b1 && smp_ready === 1'b1) expQ.push_back(smp_data);
      @(posedge clk);
      @(negedge clk);
      cycleNum++;
      if (dac_load === 1'b1) begin
         loads++;
         prevLoadCycle = lastLoadCycle;
         lastLoadCycle = cycleNum;
         check("load_expected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) begin
            front = expQ.pop_front();
            lastExpData = front;
            check("load_data", 32'(dac_data_out), 32'(front));
         end
      end
      if (dac_underrun === 1'b1) underruns++;
      if (dac_err === 1'b1) begin
         errs++;
         errCycle = cycleNum;
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic waitLoads(input int target, input int budget, input string tag);
      int n = 0;
      while (loads < target && n < budget) begin
         stepCycle();
         n++;
      end
      check(tag, 32'(loads >= target), 32'd1);
   endtask

   task automatic pushSample(input logic [DW-1:0] d);
      smp_data  = d;
      smp_valid = 1'b1;
      stepCycle();
      smp_valid = 1'b0;
   endtask

   initial begin
      int loadAt;
      int n;
      sreset_n   = 1'b0;
      dac_en     = 1'b0;
      dac_period = '0;
      smp_data   = '0;
      smp_valid  = 1'b0;
      runCycles(3);
      check("rst_data_out", 32'(dac_data_out), 32'd0);
      check("rst_load", 32'(dac_load), 32'd0);
      check("rst_underrun", 32'(dac_underrun), 32'd0);
      check("rst_err", 32'(dac_err), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ready", 32'(smp_ready), 32'd1);
      sreset_n = 1'b1;
      runCycles(1);

      // Two directed samples, paced at period 3 with the busy model active.
      busyModelOn = 1'b1;
      pushSample(10'h155);
      pushSample(10'h2AA);
      check("level_two", 32'(fifo_level), 32'd2);
      loads = 0;
      underruns = 0;
      dac_period = 8'd3;
      dac_en = 1'b1;
      waitLoads(2, 200, "two_loads");
      check("no_underrun", 32'(underruns), 32'd0);
      check("load_spacing", 32'((lastLoadCycle - prevLoadCycle) >= 7), 32'd1);
      dac_en = 1'b0;
      runCycles(20);
      check("drained_level", 32'(fifo_level), 32'd0);

      // Fill while disabled: four accepted, the fifth refused.
      for (int i = 0; i < 5; i++) begin
         smp_data  = DW'($urandom_range(0, 1023));
         smp_valid = 1'b1;
         check("ready_vs_model", 32'(smp_ready), 32'(expQ.size() < 4));
         stepCycle();
      end
      smp_valid = 1'b0;
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_ready", 32'(smp_ready), 32'd0);

      // Drop enable during the busy-low wait: transfer completes, rest retained.
      dac_period = PW'($urandom_range(0, 5));
      loads = 0;
      dac_en = 1'b1;
      waitLoads(1, 100, "first_load_en_drop");
      runCycles(4);
      dac_en = 1'b0;
      runCycles(20);
      check("en_drop_loads", 32'(loads), 32'd1);
      check("en_drop_level", 32'(fifo_level), 32'd3);
      runCycles(10);
      check("idle_level_kept", 32'(fifo_level), 32'd3);
      check("idle_no_load", 32'(loads), 32'd1);

      // Random traffic with concurrent push and pop, then drain.
      dac_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 0) dac_period = PW'($urandom_range(0, 4));
         smp_valid = ($urandom_range(0, 3) == 0);
         smp_data  = DW'($urandom_range(0, 1023));
         stepCycle();
      end
      smp_valid = 1'b0;
      n = 0;
      while (expQ.size() > 0 && n < 3000) begin
         stepCycle();
         n++;
      end
      check("random_drain", 32'(expQ.size()), 32'd0);
      dac_en = 1'b0;
      runCycles(20);
      check("random_level", 32'(fifo_level), 32'd0);
      check("random_ready", 32'(smp_ready), 32'd1);

      // Empty FIFO at period 0: an underrun every cycle, output held.
      loads = 0;
      dac_period = '0;
      dac_en = 1'b1;
      runCycles(3);
      for (int i = 0; i < 8; i++) begin
         stepCycle();
         check("underrun_pulse", 32'(dac_underrun), 32'd1);
      end
      check("underrun_no_load", 32'(loads), 32'd0);
      check("underrun_data_held", 32'(dac_data_out), 32'(lastExpData));
      dac_en = 1'b0;
      runCycles(3);

      // Busy never rises.
      busyModelOn = 1'b0;
      pushSample(DW'($urandom_range(0, 1023)));
      pushSample(DW'($urandom_range(0, 1023)));
      loads = 0;
      errs = 0;
      dac_en = 1'b1;
      waitLoads(1, 50, "load_before_timeout");
      loadAt = lastLoadCycle;
`ifdef DAC_BUSY_TIMEOUT_EN
      n = 0;
      while (errs < 1 && n < 40) begin
         stepCycle();
         n++;
      end
      check("timeout_err_seen", 32'(errs), 32'd1);
      check("timeout_err_delay", 32'(errCycle - loadAt), 32'd16);
      waitLoads(2, 50, "load_after_timeout");
`else
      runCycles(40);
      check("err_tied_low", 32'(errs), 32'd0);
      check("stuck_wait_hi", 32'(loads), 32'd1);
      check("stuck_level", 32'(fifo_level), 32'd1);
`endif

      // Reset in WAIT_HI with three samples queued.
      dac_en = 1'b0;
      sreset_n = 1'b0;
      runCycles(1);
      sreset_n = 1'b1;
      expQ.delete();
      for (int i = 0; i < 4; i++) pushSample(DW'($urandom_range(0, 1023)));
      loads = 0;
      dac_period = PW'($urandom_range(0, 3));
      dac_en = 1'b1;
      waitLoads(1, 50, "load_before_reset");
      check("queued_before_reset", 32'(fifo_level), 32'd3);
      sreset_n = 1'b0;
      stepCycle();
      check("midrst_load", 32'(dac_load), 32'd0);
      check("midrst_data_out", 32'(dac_data_out), 32'd0);
      check("midrst_underrun", 32'(dac_underrun), 32'd0);
      check("midrst_err", 32'(dac_err), 32'd0);
      check("midrst_level", 32'(fifo_level), 32'd0);
      check("midrst_ready", 32'(smp_ready), 32'd1);
      expQ.delete();
      dac_en = 1'b0;
      sreset_n = 1'b1;
      runCycles(5);
      check("post_rst_level", 32'(fifo_level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
